// File: rtl/sysctrl_pkg.sv
// Shared constants for the system control slice: register offsets,
// SYSCTRL bit positions and lock FSM encoding.
package sysctrl_pkg;

  localparam int OFF_RAMBANK  = 0;
  localparam int OFF_SYSCTRL  = 1;
  localparam int OFF_LOCKSTAT = 2;
  localparam int OFF_SCRATCH0 = 3;

  localparam int B_CPURESET = 0;
  localparam int B_CPUSTOP  = 1;
  localparam int B_BOOT     = 2;
  localparam int B_ABRT02   = 6;
  localparam int B_KEY      = 7;

  localparam logic [0:0] LOCKED   = 1'b0;
  localparam logic [0:0] UNLOCKED = 1'b1;

endpackage

// File: rtl/SB_WARMBOOT.sv
// Simulation stand-in for the iCE40 warm-boot primitive; leave this file out
// of the synthesis file list so the vendor cell is used instead.
module SB_WARMBOOT (
  input logic BOOT,
  input logic S1,
  input logic S0
);

  logic unused_pins;
  assign unused_pins = BOOT ^ S1 ^ S0;

endmodule

// File: rtl/pulse_stretch.sv
// Load/down-counter that holds its output high while counting; in sticky mode
// the output rises when the count expires and stays high until reset.
module pulse_stretch #(
  parameter int LENGTH = 16,
  parameter bit STICKY = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic busy_o,
  output logic out_o
);

  localparam int CNT_W = $clog2(LENGTH + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             load_ok;

  always_comb begin
    // Sticky instances accept one load only: none while counting or after firing.
    load_ok = load_i & (!STICKY || ((cnt_q == '0) && !out_q));
    if (load_ok)
      cnt_d = CNT_W'(LENGTH);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
    else
      cnt_d = cnt_q;
    if (STICKY)
      out_d = out_q | (cnt_q == CNT_W'(1));
    else
      out_d = (cnt_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign out_o  = out_q;

endmodule

// File: rtl/sysctrl_unit.sv
// System control register slice on the slave bus: RAM bank mask, key-protected
// SYSCTRL with unlock timeout, stretched CPU reset/stop, delayed warm boot.
module sysctrl_unit
  import sysctrl_pkg::*;
#(
  parameter int         ADDR_W      = 5,
  parameter int         RAMBANK_W   = 8,
  parameter logic [7:0] RAMBANK_RST = 8'h7F,
  parameter logic [7:0] UNLOCK_KEY  = 8'h80,
  parameter int         UNLOCK_TMO  = 64,
  parameter int         RST_PULSE   = 16,
  parameter int         BOOT_DELAY  = 4,
  parameter int         N_SCRATCH   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    slv_addr_i,
  input  logic [7:0]           slv_datawr_i,
  input  logic                 slv_datawr_valid,
  output logic [7:0]           slv_datard_o,
  input  logic                 slv_req_i,
  input  logic                 slv_rwn_i,
  output logic [RAMBANK_W-1:0] rambank_mask_o,
  output logic                 abrt02_en_o,
  output logic                 cpu_reset_req_o,
  output logic                 cpu_stop_req_o,
  output logic                 fpga_boot_o
);

  localparam int TMO_W     = $clog2(UNLOCK_TMO);
  localparam int SCR_DEPTH = (N_SCRATCH > 0) ? N_SCRATCH : 1;

  logic [RAMBANK_W-1:0] rambank_q, rambank_d;
  logic [0:0]           state_q, state_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                 abrt_q, abrt_d;
  logic                 stop_q, stop_d;
  logic                 tmo_flag_q, tmo_flag_d;
  logic                 viol_q, viol_d;
  logic [7:0]           scratch_q [SCR_DEPTH];

  logic wr, wr_sys, wr_lock, is_key, cmd, tmo_set, viol_set;
  logic boot_busy, rst_busy_unused;
  logic unlocked;

  assign wr       = slv_req_i & ~slv_rwn_i & slv_datawr_valid;
  assign wr_sys   = wr && (slv_addr_i == ADDR_W'(OFF_SYSCTRL));
  assign wr_lock  = wr && (slv_addr_i == ADDR_W'(OFF_LOCKSTAT));
  assign is_key   = (slv_datawr_i == UNLOCK_KEY);
  assign unlocked = (state_q == UNLOCKED);

  // NOTE: every combinational output gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    abrt_d    = abrt_q;
    stop_d    = 1'b0;
    cmd       = 1'b0;
    tmo_set   = 1'b0;
    viol_set  = 1'b0;
    rambank_d = rambank_q;

    if (state_q == LOCKED) begin
      if (wr_sys && is_key) begin
        state_d   = UNLOCKED;
        tmo_cnt_d = TMO_W'(UNLOCK_TMO - 1);
      end else if (wr_sys && !slv_datawr_i[B_KEY]) begin
        viol_set = 1'b1;
      end
    end else begin
      // A command beats a simultaneous expiry; other key-bit writes fall through.
      if (wr_sys && is_key) begin
        tmo_cnt_d = TMO_W'(UNLOCK_TMO - 1);
      end else if (wr_sys && !slv_datawr_i[B_KEY]) begin
        cmd       = 1'b1;
        state_d   = LOCKED;
        tmo_cnt_d = '0;
      end else if (tmo_cnt_q == '0) begin
        state_d = LOCKED;
        tmo_set = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q - 1'b1;
      end
    end

    if (cmd) begin
      abrt_d = slv_datawr_i[B_ABRT02];
      stop_d = slv_datawr_i[B_CPUSTOP];
    end

    tmo_flag_d = tmo_set  | (tmo_flag_q & ~(wr_lock & slv_datawr_i[1]));
    viol_d     = viol_set | (viol_q     & ~(wr_lock & slv_datawr_i[2]));

    if (wr && (slv_addr_i == ADDR_W'(OFF_RAMBANK)))
      rambank_d = slv_datawr_i[RAMBANK_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rambank_q  <= RAMBANK_RST[RAMBANK_W-1:0];
      state_q    <= LOCKED;
      tmo_cnt_q  <= '0;
      abrt_q     <= 1'b0;
      stop_q     <= 1'b0;
      tmo_flag_q <= 1'b0;
      viol_q     <= 1'b0;
    end else begin
      rambank_q  <= rambank_d;
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      abrt_q     <= abrt_d;
      stop_q     <= stop_d;
      tmo_flag_q <= tmo_flag_d;
      viol_q     <= viol_d;
    end
  end

  // NOTE: the scratch array is a handful of software-visible flops, not a RAM,
  // so it is reset like any other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SCR_DEPTH; i++) scratch_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < N_SCRATCH; i++)
        if (wr && (slv_addr_i == ADDR_W'(OFF_SCRATCH0 + i)))
          scratch_q[i] <= slv_datawr_i;
    end
  end

  pulse_stretch #(.LENGTH(RST_PULSE), .STICKY(1'b0)) u_rst_pulse (
    .clk    (clk),
    .reset  (reset),
    .load_i (cmd & slv_datawr_i[B_CPURESET]),
    .busy_o (rst_busy_unused),
    .out_o  (cpu_reset_req_o)
  );

  pulse_stretch #(.LENGTH(BOOT_DELAY), .STICKY(1'b1)) u_boot_delay (
    .clk    (clk),
    .reset  (reset),
    .load_i (cmd & slv_datawr_i[B_BOOT]),
    .busy_o (boot_busy),
    .out_o  (fpga_boot_o)
  );

  SB_WARMBOOT u_warmboot (
    .BOOT (fpga_boot_o),
    .S1   (1'b0),
    .S0   (1'b0)
  );

  always_comb begin
    slv_datard_o = 8'h00;
    if (slv_req_i) begin
      if (slv_addr_i == ADDR_W'(OFF_RAMBANK))
        slv_datard_o = 8'(rambank_q);
      else if (slv_addr_i == ADDR_W'(OFF_SYSCTRL))
        slv_datard_o = {unlocked, abrt_q, 3'b000, boot_busy, 1'b0, cpu_reset_req_o};
      else if (slv_addr_i == ADDR_W'(OFF_LOCKSTAT))
        slv_datard_o = {5'b00000, viol_q, tmo_flag_q, unlocked};
      for (int i = 0; i < N_SCRATCH; i++)
        if (slv_addr_i == ADDR_W'(OFF_SCRATCH0 + i))
          slv_datard_o = scratch_q[i];
    end
  end

  assign rambank_mask_o = rambank_q;
  assign abrt02_en_o    = abrt_q;
  assign cpu_stop_req_o = stop_q;

endmodule

// File: doc/sysctrl_unit.md
Name: sysctrl_unit

Overview:
Parametrised successor of the system control register slice at the NORA slave bus. It holds the RAM bank mask, a key-protected SYSCTRL register with an unlock timeout, and stretched CPU reset and stop requests. It also provides a delayed FPGA warm-boot request, sticky lock-status flags and general scratch registers. The top level instantiates the SB_WARMBOOT primitive from fpga_boot_o.

Parameters:
ADDR_W, 5, slave address width
RAMBANK_W, 8, RAMBANK_MASK width (1..8; unused read bits are 0)
RAMBANK_RST, 8'h7F, RAMBANK_MASK reset value (X16 compatible)
UNLOCK_KEY, 8'h80, SYSCTRL unlock key
UNLOCK_TMO, 64, cycles the unlock window stays open (>=2)
RST_PULSE, 16, cycles cpu_reset_req_o is held high (>=1)
BOOT_DELAY, 4, cycles from boot command to fpga_boot_o (>=1)
N_SCRATCH, 2, number of 8-bit scratch registers (0..8)

Ports:
clk  in  1  system clock, 48 MHz
reset  in  1  synchronous reset, active-high
slv_addr_i  in  ADDR_W  block-local register offset
slv_datawr_i  in  8  write data, valid only with slv_datawr_valid
slv_datawr_valid  in  1  access strobe, end of CPU cycle
slv_datard_o  out  8  read data, combinational
slv_req_i  in  1  block chip select
slv_rwn_i  in  1  1=read, 0=write
rambank_mask_o  out  RAMBANK_W  RAM bank mask
abrt02_en_o  out  1  ABRT02 enable
cpu_reset_req_o  out  1  CPU reset request, stretched
cpu_stop_req_o  out  1  CPU stop request, one-cycle pulse
fpga_boot_o  out  1  warm-boot trigger, sticky until reset

Behaviour:
- Write strobe: wr = slv_req_i & !slv_rwn_i & slv_datawr_valid. All register updates occur on the clk edge after wr.
- Register map:
  - 0 RAMBANK_MASK, R/W.
  - 1 SYSCTRL.
  - 2 LOCKSTAT.
  - 3..3+N_SCRATCH-1 SCRATCH, R/W.
  - Any other offset reads 0x00 and ignores writes.
- Read data:
  - Combinational from slv_addr_i; 0x00 when slv_req_i=0.
  - SYSCTRL reads {unlocked, abrt02_en, 3'b0, boot_pending, 1'b0, rst_active}.
  - LOCKSTAT reads {5'b0, viol, tmo, unlocked}.
- Reset values:
  - rambank_mask_o=RAMBANK_RST; abrt02_en_o=0; cpu_reset_req_o=0; cpu_stop_req_o=0; fpga_boot_o=0.
  - Scratch registers=0; tmo=0; viol=0; FSM=LOCKED; all counters=0.
- Lock FSM, LOCKED:
  - Write of UNLOCK_KEY to SYSCTRL -> UNLOCKED, tmo_cnt=UNLOCK_TMO-1.
  - Any other SYSCTRL write with bit7=0 is ignored and sets viol.
- Lock FSM, UNLOCKED:
  - tmo_cnt decrements each cycle.
  - tmo_cnt reaching 0 with no command -> LOCKED and sets tmo.
  - Another UNLOCK_KEY write reloads tmo_cnt and stays UNLOCKED.
  - A SYSCTRL write with bit7=0 is a command and goes to LOCKED the same edge:
    - abrt02_en_o <= d[6].
    - d[0]: rst_cnt=RST_PULSE; cpu_reset_req_o goes high next cycle for exactly RST_PULSE cycles. Re-trigger while active reloads the count.
    - d[1]: cpu_stop_req_o=1 for exactly one cycle.
    - d[2]: boot_pending=1; boot_cnt=BOOT_DELAY. At expiry fpga_boot_o=1 and stays high; a second boot command is ignored.
  - A write with bit7=1 but not UNLOCK_KEY is ignored and does not relock.
  - A command in the same cycle as timeout expiry is executed (command wins).
- LOCKSTAT writes are write-1-to-clear for bits [2:1]. A set event in the same cycle as a clear leaves the bit set (set wins). Bit0 is read-only.
- Reads have no side effects.
- Reset mid-pulse or mid-boot-delay aborts it; outputs return to reset values on the next edge.

Decomposition:
- Shared package sysctrl_pkg holds:
  - register offset constants (OFF_RAMBANK=0, OFF_SYSCTRL=1, OFF_LOCKSTAT=2, OFF_SCRATCH0=3);
  - SYSCTRL bit indices (B_CPURESET=0, B_CPUSTOP=1, B_BOOT=2, B_ABRT02=6, B_KEY=7);
  - FSM state encoding (LOCKED, UNLOCKED).
- One sub-module, pulse_stretch: parametrised load/down-counter producing a held-high output. It is instantiated for the reset pulse and for the boot delay (sticky mode).

Test Plan:
- After reset, read offsets 0/1/2 -> 0x7F / 0x00 / 0x00; all request outputs 0.
- Write 0x80, then 0x01 to SYSCTRL -> cpu_reset_req_o high exactly 16 cycles starting the cycle after the write; LOCKSTAT bit0 returns to 0.
- Write 0x80, wait 64 cycles, write 0x02 -> no cpu_stop_req_o; LOCKSTAT=0x06 (tmo and viol set); write 0x06 to LOCKSTAT -> reads 0x00.
- Write 0x80, then 0x44 -> abrt02_en_o=1; fpga_boot_o rises 4 cycles after the write and holds; SYSCTRL reads 0x44 during the delay.
- Write 0x80, 0x01, then assert reset at pulse cycle 5 -> cpu_reset_req_o low on the next edge and stays low.
- Write 0x5A to offset 4 and 0xA5 to RAMBANK_MASK -> reads 0x5A and 0xA5; offset 31 reads 0x00; a read with slv_req_i=0 returns 0x00.
